// File: rtl/gpu_tri_scan.sv
// rtl/gpu_tri_scan.sv - triangle rasteriser: primitive FIFO feeding a bounding-box edge-function scan
// All state advances on the falling edge of I_CLOCK to line up with the surrounding pipeline.
module gpu_tri_scan #(
    parameter int FIFO_DEPTH = 2,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480
) (
    input  logic        I_CLOCK,
    input  logic        I_RESET_N,
    input  logic        I_LOCK,
    input  logic [15:0] I_GSRValue,
    input  logic        I_GSRValue_Valid,
    input  logic [29:0] I_VertexV1,
    input  logic [29:0] I_VertexV2,
    input  logic [29:0] I_VertexV3,
    input  logic        I_FB_Ready,
    output logic        O_GPUStallSignal,
    output logic        O_PixelValid,
    output logic [9:0]  O_PixelX,
    output logic [9:0]  O_PixelY,
    output logic [11:0] O_PixelColor,
    output logic        O_Busy,
    output logic        O_PrimDone
);

    localparam int              PW       = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam logic [2:0]      DEPTH    = 3'(FIFO_DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [9:0]      XLIM     = 10'(SCREEN_W - 1);
    localparam logic [9:0]      YLIM     = 10'(SCREEN_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SCAN} state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [71:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [2:0]     r_count;
    logic           w_push;
    logic           w_pop;
    logic [71:0]    w_wdata;

    logic [11:0]    r_col;
    logic [9:0]     r_x1, r_y1, r_x2, r_y2, r_x3, r_y3;
    logic [9:0]     r_x, r_y;
    logic [9:0]     r_xmin, r_xmax, r_ymax;
    logic           r_area_pos;
    logic           r_done;

    logic [9:0]     w_xmin, w_xmax, w_ymin, w_ymax;
    logic signed [22:0] w_area;
    logic signed [22:0] w_e1, w_e2, w_e3;
    logic           w_degen;
    logic           w_inside;
    logic           w_adv;
    logic           w_last;
    logic           w_unused_bits;

    // Cross product (b-a) x (p-a); with p = V3 on edge V1V2 this is the signed area,
    // so interior points share the sign of A on every edge.
    function automatic logic signed [22:0] f_cross(input logic [9:0] ax, input logic [9:0] ay,
                                                   input logic [9:0] bx, input logic [9:0] by,
                                                   input logic [9:0] px, input logic [9:0] py);
        logic signed [10:0] dxb, dyb, dxp, dyp;
        dxb = $signed({1'b0, bx}) - $signed({1'b0, ax});
        dyb = $signed({1'b0, by}) - $signed({1'b0, ay});
        dxp = $signed({1'b0, px}) - $signed({1'b0, ax});
        dyp = $signed({1'b0, py}) - $signed({1'b0, ay});
        return 23'(dxb) * 23'(dyp) - 23'(dyb) * 23'(dxp);
    endfunction

    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_unused_bits = ^{I_GSRValue[15:12], I_VertexV1[9:0], I_VertexV2[9:0], I_VertexV3[9:0]};

    assign w_wdata = {I_GSRValue[11:0], I_VertexV1[29:10], I_VertexV2[29:10], I_VertexV3[29:10]};
    assign w_push  = I_GSRValue_Valid && I_LOCK && (r_count < DEPTH);
    assign w_pop   = I_LOCK && (r_state == S_IDLE) && (r_count != 3'd0);

    always_comb begin
        w_xmin = r_x1;
        if (r_x2 < w_xmin) w_xmin = r_x2;
        if (r_x3 < w_xmin) w_xmin = r_x3;
        w_ymin = r_y1;
        if (r_y2 < w_ymin) w_ymin = r_y2;
        if (r_y3 < w_ymin) w_ymin = r_y3;
        w_xmax = r_x1;
        if (r_x2 > w_xmax) w_xmax = r_x2;
        if (r_x3 > w_xmax) w_xmax = r_x3;
        if (w_xmax > XLIM) w_xmax = XLIM;
        w_ymax = r_y1;
        if (r_y2 > w_ymax) w_ymax = r_y2;
        if (r_y3 > w_ymax) w_ymax = r_y3;
        if (w_ymax > YLIM) w_ymax = YLIM;
    end

    assign w_area  = f_cross(r_x1, r_y1, r_x2, r_y2, r_x3, r_y3);
    assign w_degen = (w_area == 23'sd0) || (w_xmin > w_xmax) || (w_ymin > w_ymax);

    assign w_e1 = f_cross(r_x1, r_y1, r_x2, r_y2, r_x, r_y);
    assign w_e2 = f_cross(r_x2, r_y2, r_x3, r_y3, r_x, r_y);
    assign w_e3 = f_cross(r_x3, r_y3, r_x1, r_y1, r_x, r_y);

    assign w_inside = r_area_pos ?
        (!w_e1[22] && !w_e2[22] && !w_e3[22]) :
        ((w_e1[22] || w_e1 == 23'sd0) && (w_e2[22] || w_e2 == 23'sd0) && (w_e3[22] || w_e3 == 23'sd0));

    assign w_adv  = !w_inside || I_FB_Ready;
    assign w_last = (r_x == r_xmax) && (r_y == r_ymax);

    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_count != 3'd0) w_state_nxt = S_SETUP;
            S_SETUP: w_state_nxt = w_degen ? S_IDLE : S_SCAN;
            S_SCAN:  if (w_adv && w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (!I_LOCK) w_state_nxt = S_IDLE;
    end

    always_ff @(negedge I_CLOCK) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wdata;
    end

    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_done     <= 1'b0;
            r_col      <= '0;
            r_x1       <= '0;
            r_y1       <= '0;
            r_x2       <= '0;
            r_y2       <= '0;
            r_x3       <= '0;
            r_y3       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_xmin     <= '0;
            r_xmax     <= '0;
            r_ymax     <= '0;
            r_area_pos <= 1'b0;
        end else if (!I_LOCK) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
            if (w_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
                {r_col, r_x1, r_y1, r_x2, r_y2, r_x3, r_y3} <= r_mem[r_rd_ptr];
            end
            if (r_state == S_SETUP) begin
                r_xmin     <= w_xmin;
                r_xmax     <= w_xmax;
                r_ymax     <= w_ymax;
                r_x        <= w_xmin;
                r_y        <= w_ymin;
                r_area_pos <= !w_area[22];
                r_done     <= w_degen;
            end
            if ((r_state == S_SCAN) && w_adv) begin
                if (w_last) begin
                    r_done <= 1'b1;
                end else if (r_x == r_xmax) begin
                    r_x <= r_xmin;
                    r_y <= r_y + 10'd1;
                end else begin
                    r_x <= r_x + 10'd1;
                end
            end
        end
    end

    assign O_GPUStallSignal = I_LOCK && (r_count == DEPTH);
    assign O_PixelValid     = (r_state == S_SCAN) && w_inside;
    assign O_PixelX         = r_x;
    assign O_PixelY         = r_y;
    assign O_PixelColor     = r_col;
    assign O_Busy           = (r_state != S_IDLE) || (r_count != 3'd0);
    assign O_PrimDone       = r_done;

endmodule

// File: tb/tb_gpu_tri_scan.sv
// tb/tb_gpu_tri_scan.sv - directed self-checking bench for gpu_tri_scan
module tb_gpu_tri_scan;

    logic        I_CLOCK;
    logic        I_RESET_N;
    logic        I_LOCK;
    logic [15:0] I_GSRValue;
    logic        I_GSRValue_Valid;
    logic [29:0] I_VertexV1, I_VertexV2, I_VertexV3;
    logic        I_FB_Ready;
    logic        O_GPUStallSignal;
    logic        O_PixelValid;
    logic [9:0]  O_PixelX, O_PixelY;
    logic [11:0] O_PixelColor;
    logic        O_Busy;
    logic        O_PrimDone;

    gpu_tri_scan #(.FIFO_DEPTH(2), .SCREEN_W(640), .SCREEN_H(480)) dut (
        .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK),
        .I_GSRValue(I_GSRValue), .I_GSRValue_Valid(I_GSRValue_Valid),
        .I_VertexV1(I_VertexV1), .I_VertexV2(I_VertexV2), .I_VertexV3(I_VertexV3),
        .I_FB_Ready(I_FB_Ready), .O_GPUStallSignal(O_GPUStallSignal),
        .O_PixelValid(O_PixelValid), .O_PixelX(O_PixelX), .O_PixelY(O_PixelY),
        .O_PixelColor(O_PixelColor), .O_Busy(O_Busy), .O_PrimDone(O_PrimDone)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [9:0]  q_x[$];
    logic [9:0]  q_y[$];
    logic [11:0] q_c[$];
    int done_cnt, done_edge, first_valid_edge, stall_samples, hold_err;
    logic prev_stalled;
    logic [31:0] prev_pix;

    initial begin
        I_CLOCK = 1'b0;
        forever #5 I_CLOCK = ~I_CLOCK;
    end

    always @(negedge I_CLOCK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observer: samples just after the rising edge, midway between active falling edges.
    initial begin
        hold_err = 0;
        forever begin
            @(posedge I_CLOCK);
            #1;
            if (I_RESET_N) begin
                if (prev_stalled && !(O_PixelValid && {2'b0, O_PixelX, O_PixelY, O_PixelColor} == prev_pix))
                    hold_err++;
                if (O_PixelValid && I_FB_Ready) begin
                    q_x.push_back(O_PixelX);
                    q_y.push_back(O_PixelY);
                    q_c.push_back(O_PixelColor);
                end
                if (O_PixelValid && !I_FB_Ready) stall_samples++;
                if (O_PixelValid && first_valid_edge < 0) first_valid_edge = cyc;
                if (O_PrimDone) begin
                    done_cnt++;
                    done_edge = cyc;
                end
                prev_stalled = O_PixelValid && !I_FB_Ready;
                prev_pix     = {2'b0, O_PixelX, O_PixelY, O_PixelColor};
            end
        end
    end

    task automatic clear_mon();
        q_x.delete();
        q_y.delete();
        q_c.delete();
        done_cnt         = 0;
        done_edge        = -1;
        first_valid_edge = -1;
        stall_samples    = 0;
        prev_stalled     = 1'b0;
    endtask

    task automatic set_prim(input logic [11:0] col, input logic [9:0] x1, input logic [9:0] y1,
                            input logic [9:0] x2, input logic [9:0] y2,
                            input logic [9:0] x3, input logic [9:0] y3);
        I_GSRValue = {4'hA, col};
        I_VertexV1 = {x1, y1, 10'h3FF};
        I_VertexV2 = {x2, y2, 10'h155};
        I_VertexV3 = {x3, y3, 10'h2AA};
    endtask

    task automatic push(input logic [11:0] col, input logic [9:0] x1, input logic [9:0] y1,
                        input logic [9:0] x2, input logic [9:0] y2,
                        input logic [9:0] x3, input logic [9:0] y3, output int pe);
        set_prim(col, x1, y1, x2, y2, x3, y3);
        I_GSRValue_Valid = 1'b1;
        pe = cyc + 1;
        @(posedge I_CLOCK);
        I_GSRValue_Valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 400) begin
            @(posedge I_CLOCK);
            n++;
        end
        check(tag, 32'(done_cnt >= target), 32'd1);
        repeat (2) @(posedge I_CLOCK);
    endtask

    task automatic wait_edge(input int target, input string tag);
        int n = 0;
        while (cyc != target && n < 100) begin
            @(posedge I_CLOCK);
            n++;
        end
        check(tag, 32'(cyc == target), 32'd1);
    endtask

    task automatic check_small(input string tag, input logic [11:0] col, input int base);
        int idx = base;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                if (x + y <= 3) begin
                    if (idx < q_x.size())
                        check($sformatf("%s_pix%0d", tag, idx - base),
                              {q_x[idx], q_y[idx], q_c[idx]}, {10'(x), 10'(y), col});
                    else
                        check($sformatf("%s_missing%0d", tag, idx - base), 32'd0, 32'd1);
                    idx++;
                end
            end
        end
    endtask

    int pe, n, cnt_bad, xmn, xmx, ymn, ymx;

    initial begin
        I_RESET_N = 1'b1;
        I_LOCK = 1'b1;
        I_FB_Ready = 1'b1;
        I_GSRValue_Valid = 1'b0;
        set_prim(12'h000, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);
        clear_mon();
        #2 I_RESET_N = 1'b0;
        repeat (2) @(posedge I_CLOCK);
        #1;
        check("rst_flags", {28'd0, O_GPUStallSignal, O_PixelValid, O_Busy, O_PrimDone}, 32'd0);
        check("rst_pix", {O_PixelX, O_PixelY, O_PixelColor}, 32'd0);
        @(posedge I_CLOCK);
        I_RESET_N = 1'b1;
        @(posedge I_CLOCK);

        // Basic triangle, always ready
        clear_mon();
        push(12'hF00, 10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd3, pe);
        wait_done(1, "t1_done_seen");
        check("t1_count", q_x.size(), 32'd10);
        check_small("t1", 12'hF00, 0);
        check("t1_first_lat", first_valid_edge, pe + 2);
        check("t1_done_lat", done_edge, pe + 18);
        check("t1_scan_cycles", done_edge - first_valid_edge, 32'd16);
        check("t1_done_pulses", done_cnt, 32'd1);
        check("t1_idle", {31'd0, O_Busy}, 32'd0);

        // Framebuffer back-pressure at (1,1) for three cycles
        clear_mon();
        push(12'hF00, 10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd3, pe);
        wait_edge(pe + 7, "t2_reach");
        check("t2_at11", {O_PixelValid, O_PixelX, O_PixelY}, {1'b1, 10'd1, 10'd1});
        I_FB_Ready = 1'b0;
        repeat (3) @(posedge I_CLOCK);
        I_FB_Ready = 1'b1;
        wait_done(1, "t2_done_seen");
        check("t2_stall_samples", stall_samples, 32'd3);
        check("t2_count", q_x.size(), 32'd10);
        check_small("t2", 12'hF00, 0);
        check("t2_done_lat", done_edge, pe + 21);

        // Degenerate primitive
        clear_mon();
        push(12'h0F0, 10'd0, 10'd0, 10'd2, 10'd2, 10'd4, 10'd4, pe);
        wait_done(1, "t3_done_seen");
        check("t3_no_valid", first_valid_edge, 32'hFFFF_FFFF);
        check("t3_count", q_x.size(), 32'd0);
        check("t3_done_lat", done_edge, pe + 2);

        // FIFO full, dropped push, held push
        clear_mon();
        push(12'h0A0, 10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd3, pe);
        repeat (3) @(posedge I_CLOCK);
        set_prim(12'h0B0, 10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd3);
        I_GSRValue_Valid = 1'b1;
        @(posedge I_CLOCK);
        set_prim(12'h0C0, 10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd3);
        @(posedge I_CLOCK);
        check("t4_stall_full", {31'd0, O_GPUStallSignal}, 32'd1);
        set_prim(12'h00F, 10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd3);
        @(posedge I_CLOCK);
        I_GSRValue_Valid = 1'b0;
        check("t4_stall_after_drop", {31'd0, O_GPUStallSignal}, 32'd1);
        set_prim(12'hABC, 10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd3);
        I_GSRValue_Valid = 1'b1;
        n = 0;
        while (O_GPUStallSignal && n < 100) begin
            @(posedge I_CLOCK);
            n++;
        end
        check("t4_stall_release", 32'(n < 100 && n > 0), 32'd1);
        @(posedge I_CLOCK);
        I_GSRValue_Valid = 1'b0;
        wait_done(4, "t4_done_seen");
        check("t4_count", q_x.size(), 32'd40);
        cnt_bad = 0;
        foreach (q_c[i]) if (q_c[i] == 12'h00F) cnt_bad++;
        check("t4_dropped_absent", cnt_bad, 32'd0);
        check_small("t4a", 12'h0A0, 0);
        check_small("t4b", 12'h0B0, 10);
        check_small("t4c", 12'h0C0, 20);
        check_small("t4d", 12'hABC, 30);

        // Screen-edge clamp
        clear_mon();
        push(12'h555, 10'd630, 10'd470, 10'd700, 10'd470, 10'd630, 10'd520, pe);
        wait_done(1, "t5_done_seen");
        check("t5_count", q_x.size(), 32'd100);
        xmn = 1023; xmx = 0; ymn = 1023; ymx = 0; cnt_bad = 0;
        foreach (q_x[i]) begin
            if (q_x[i] < xmn) xmn = q_x[i];
            if (q_x[i] > xmx) xmx = q_x[i];
            if (q_y[i] < ymn) ymn = q_y[i];
            if (q_y[i] > ymx) ymx = q_y[i];
            if (q_x[i] < 630 || q_x[i] > 639 || q_y[i] < 470 || q_y[i] > 479) cnt_bad++;
        end
        check("t5_xrange", {xmn[15:0], xmx[15:0]}, {16'd630, 16'd639});
        check("t5_yrange", {ymn[15:0], ymx[15:0]}, {16'd470, 16'd479});
        check("t5_out_of_clamp", cnt_bad, 32'd0);
        if (q_x.size() == 100)
            check("t5_first_last", {q_x[0], q_y[0], q_x[99]}, {10'd630, 10'd470, 10'd639});
        else
            check("t5_first_last", 32'd0, 32'd1);

        // Reset mid-scan, then a push on the first edge after release
        clear_mon();
        push(12'h123, 10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd3, pe);
        push(12'h456, 10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd3, n);
        wait_edge(pe + 8, "t6_reach");
        check("t6_pre_rst", {O_Busy, O_PixelValid, O_PixelX, O_PixelY}, {1'b1, 1'b1, 10'd2, 10'd1});
        I_RESET_N = 1'b0;
        #1;
        check("t6_rst_flags", {28'd0, O_GPUStallSignal, O_PixelValid, O_Busy, O_PrimDone}, 32'd0);
        check("t6_rst_pix", {O_PixelX, O_PixelY, O_PixelColor}, 32'd0);
        @(posedge I_CLOCK);
        clear_mon();
        I_RESET_N = 1'b1;
        push(12'h789, 10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd3, pe);
        wait_done(1, "t6_done_seen");
        check("t6_count", q_x.size(), 32'd10);
        check_small("t6", 12'h789, 0);
        check("t6_first_lat", first_valid_edge, pe + 2);

        // Lock drop mid-scan with a full FIFO
        clear_mon();
        push(12'h321, 10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd3, pe);
        push(12'h654, 10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd3, n);
        push(12'h987, 10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd3, n);
        wait_edge(pe + 8, "t7_reach");
        check("t7_pre_lock", {30'd0, O_GPUStallSignal, O_PixelValid}, 32'd3);
        I_LOCK = 1'b0;
        #1;
        check("t7_stall_low", {31'd0, O_GPUStallSignal}, 32'd0);
        @(posedge I_CLOCK);
        set_prim(12'h0FF, 10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd3);
        I_GSRValue_Valid = 1'b1;
        #1;
        check("t7_lock_flags", {28'd0, O_GPUStallSignal, O_PixelValid, O_Busy, O_PrimDone}, 32'd0);
        @(posedge I_CLOCK);
        I_GSRValue_Valid = 1'b0;
        I_LOCK = 1'b1;
        @(posedge I_CLOCK);
        check("t7_fifo_empty", {31'd0, O_Busy}, 32'd0);
        clear_mon();
        push(12'h0E0, 10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd3, pe);
        wait_done(1, "t7_done_seen");
        check("t7_count", q_x.size(), 32'd10);
        check_small("t7", 12'h0E0, 0);
        check("t7_done_pulses", done_cnt, 32'd1);

        check("hold_stable", hold_err, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
